// File: rtl/vc_plane_scheduler_if.sv
// Port-side bundle of one VC plane scheduler: buffer requests and flit pops in,
// the three plane selectors and status flags out.
interface vc_plane_scheduler_if #(
   parameter int VC         = 4,
   parameter int TYPE_WIDTH = 2
);
   logic [VC:0]           plane_req;
   logic                  flit_pop;
   logic [TYPE_WIDTH-1:0] flit_type;
   logic [VC:0]           VCPlaneSelectorCFSM;
   logic [VC:0]           VCPlaneSelectorHFB;
   logic [VC:0]           VCPlaneSelectorVCG;
   logic                  active_valid;
   logic                  protocol_error;

   modport master (
      output plane_req, flit_pop, flit_type,
      input  VCPlaneSelectorCFSM, VCPlaneSelectorHFB, VCPlaneSelectorVCG,
             active_valid, protocol_error
   );

   modport slave (
      input  plane_req, flit_pop, flit_type,
      output VCPlaneSelectorCFSM, VCPlaneSelectorHFB, VCPlaneSelectorVCG,
             active_valid, protocol_error
   );
endinterface

// File: rtl/vc_plane_scheduler.sv
// Round-robin VC plane scheduler for one router port: grants a plane per packet,
// pre-empts planes stuck before their head flit, and flags malformed packets.
module vc_plane_scheduler #(
   parameter int VC            = 4,
   parameter int TYPE_WIDTH    = 2,
   parameter int HEAD_TYPE     = 1,
   parameter int TAIL_TYPE     = 3,
   parameter int FlitPerPacket = 6,
   parameter int HEAD_TIMEOUT  = 16
) (
   input logic                 clk,
   input logic                 rst,
   vc_plane_scheduler_if.slave bus
);
   localparam int NP = VC + 1;
   localparam int IW = (NP > 1) ? $clog2(NP) : 1;
   localparam int FW = $clog2(FlitPerPacket + 1);

   typedef enum logic [1:0] {IDLE, GRANTED, LOCKED} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] last, last_nx;
   logic [VC:0]   sel, sel_nx;
   logic          av;
   logic [7:0]    hold_cnt, hold_nx;
   logic [FW-1:0] flit_cnt, flit_nx;
   logic          perr, perr_nx;

   logic [VC:0]   cur_oh, arb_req;
   logic [IW-1:0] arb_idx, probe;
   logic          arb_found, rearb;
   logic          is_head, is_tail, req_cur;

   assign cur_oh  = NP'(1) << last;
   assign is_head = bus.flit_type == TYPE_WIDTH'(HEAD_TYPE);
   assign is_tail = bus.flit_type == TYPE_WIDTH'(TAIL_TYPE);
   assign req_cur = bus.plane_req[last];

   // Once a plane holds the grant it is masked out, so a re-arbitration can
   // never hand the port straight back to the plane being released.
   assign arb_req = bus.plane_req & ~((state == IDLE) ? '0 : cur_oh);

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = last;
      probe     = last;
      for (int k = NP; k >= 1; k--) begin
         probe = IW'((int'(last) + k) % NP);
         if (arb_req[probe]) begin
            arb_found = 1'b1;
            arb_idx   = probe;
         end
      end
   end

   always_comb begin
      state_nx = state;
      last_nx  = last;
      sel_nx   = sel;
      hold_nx  = hold_cnt;
      flit_nx  = flit_cnt;
      perr_nx  = perr;
      rearb    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.flit_pop) perr_nx = 1'b1;
            rearb = 1'b1;
         end
         GRANTED: begin
            if (bus.flit_pop && is_tail) begin
               rearb = 1'b1;
            end else if (bus.flit_pop && is_head) begin
               state_nx = LOCKED;
               flit_nx  = FW'(1);
               hold_nx  = '0;
            end else begin
               if (bus.flit_pop) perr_nx = 1'b1;
               if (!req_cur) begin
                  state_nx = IDLE;
                  sel_nx   = '0;
                  hold_nx  = '0;
               end else if (hold_cnt >= 8'(HEAD_TIMEOUT)) begin
                  if (arb_found) rearb = 1'b1;
               end else begin
                  hold_nx = hold_cnt + 8'd1;
               end
            end
         end
         LOCKED: begin
            if (bus.flit_pop) begin
               if (is_tail) begin
                  rearb = 1'b1;
               end else if (flit_cnt == FW'(FlitPerPacket)) begin
                  perr_nx = 1'b1;
                  rearb   = 1'b1;
               end else begin
                  flit_nx = flit_cnt + FW'(1);
                  if (is_head) perr_nx = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      // Hand-over happens in the same edge as the release: no bubble cycle.
      if (rearb) begin
         hold_nx = '0;
         flit_nx = '0;
         if (arb_found) begin
            state_nx = GRANTED;
            last_nx  = arb_idx;
            sel_nx   = NP'(1) << arb_idx;
         end else begin
            state_nx = IDLE;
            sel_nx   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last     <= IW'(VC);
         sel      <= '0;
         av       <= 1'b0;
         hold_cnt <= '0;
         flit_cnt <= '0;
         perr     <= 1'b0;
      end else begin
         state    <= state_nx;
         last     <= last_nx;
         sel      <= sel_nx;
         av       <= |sel_nx;
         hold_cnt <= hold_nx;
         flit_cnt <= flit_nx;
         perr     <= perr_nx;
      end
   end

   assign bus.VCPlaneSelectorCFSM = sel;
   assign bus.VCPlaneSelectorHFB  = sel;
   assign bus.VCPlaneSelectorVCG  = sel;
   assign bus.active_valid        = av;
   assign bus.protocol_error      = perr;
endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Directed bench for vc_plane_scheduler: stimulus queues expected output-change
// events (value and cycle); a monitor pops and compares on every change.
module tb_vc_plane_scheduler;
   localparam logic [1:0] HEAD = 2'd1;
   localparam logic [1:0] BODY = 2'd2;
   localparam logic [1:0] TAIL = 2'd3;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   typedef struct {
      logic [4:0] sel;
      logic       perr;
      int         at;
   } exp_t;
   exp_t q[$];

   vc_plane_scheduler_if #(.VC(4), .TYPE_WIDTH(2)) b ();

   vc_plane_scheduler #(
      .VC(4), .TYPE_WIDTH(2), .HEAD_TYPE(1), .TAIL_TYPE(3),
      .FlitPerPacket(6), .HEAD_TIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] r, input logic pop, input logic [1:0] t);
      b.plane_req = r;
      b.flit_pop  = pop;
      b.flit_type = t;
   endtask

   task automatic exp_ev(input logic [4:0] s, input logic p, input int d);
      exp_t e;
      e.sel  = s;
      e.perr = p;
      e.at   = cyc + d;
      q.push_back(e);
   endtask

   // Monitor: an event is any change of selector/valid/error (or the first sample).
   initial begin
      logic [6:0] prev;
      logic [6:0] snap;
      logic       first;
      exp_t       e;
      first = 1'b1;
      prev  = '0;
      forever begin
         @(negedge clk);
         snap = {b.VCPlaneSelectorCFSM, b.active_valid, b.protocol_error};
         if (first || snap != prev) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d sel=%b av=%b perr=%b", cyc,
                        b.VCPlaneSelectorCFSM, b.active_valid, b.protocol_error);
            end else begin
               e = q.pop_front();
               if (b.VCPlaneSelectorCFSM != e.sel || b.active_valid != (|e.sel) ||
                   b.protocol_error != e.perr || cyc != e.at) begin
                  errors++;
                  $display("FAIL event got sel=%b av=%b perr=%b cyc=%0d want sel=%b av=%b perr=%b cyc=%0d",
                           b.VCPlaneSelectorCFSM, b.active_valid, b.protocol_error, cyc,
                           e.sel, |e.sel, e.perr, e.at);
               end
            end
         end
         prev  = snap;
         first = 1'b0;
         checks++;
         if (b.VCPlaneSelectorHFB != b.VCPlaneSelectorCFSM || b.VCPlaneSelectorVCG != b.VCPlaneSelectorCFSM ||
             !$onehot0(b.VCPlaneSelectorCFSM) || b.active_valid != (|b.VCPlaneSelectorCFSM)) begin
            errors++;
            $display("FAIL selector_invariant cyc=%0d cfsm=%b hfb=%b vcg=%b av=%b", cyc,
                     b.VCPlaneSelectorCFSM, b.VCPlaneSelectorHFB, b.VCPlaneSelectorVCG, b.active_valid);
         end
      end
   end

   logic [4:0] order [5];

   initial begin
      checks = 0;
      errors = 0;
      order  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      rst = 1'b0;
      drive(5'b0, 1'b0, 2'd0);
      exp_ev(5'b00000, 1'b0, 1);
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // single request: grant one cycle after sampling, then drop -> idle
      drive(5'b00100, 1'b0, 2'd0); exp_ev(5'b00100, 1'b0, 1); tick();
      drive(5'b00000, 1'b0, 2'd0); exp_ev(5'b00000, 1'b0, 1); tick(); tick();
      rst = 1'b0; tick(); rst = 1'b1; tick();

      // all planes request, back-to-back 3-flit packets
      drive(5'b11111, 1'b0, 2'd0); exp_ev(5'b00001, 1'b0, 1); tick();
      for (int i = 0; i < 5; i++) begin
         drive(5'b11111, 1'b1, HEAD); tick();
         drive(5'b11111, 1'b1, BODY); tick();
         drive(5'b11111, 1'b1, TAIL); exp_ev(order[i], 1'b0, 1); tick();
      end

      // plane 0 req drops -> idle, then plane 1; plane 1 held while its req is low
      drive(5'b01010, 1'b0, 2'd0); exp_ev(5'b00000, 1'b0, 1); exp_ev(5'b00010, 1'b0, 2);
      tick(); tick();
      drive(5'b01010, 1'b1, HEAD); tick();
      drive(5'b01010, 1'b1, BODY); tick();
      drive(5'b01000, 1'b0, 2'd0); repeat (5) tick();
      drive(5'b01000, 1'b1, TAIL); exp_ev(5'b01000, 1'b0, 1); tick();
      drive(5'b01000, 1'b0, 2'd0); repeat (8) tick();

      // head timeout pre-emption (timeout 4), then lone requester keeps grant
      drive(5'b01001, 1'b0, 2'd0); exp_ev(5'b00001, 1'b0, 1); exp_ev(5'b01000, 1'b0, 6);
      repeat (6) tick();
      drive(5'b00001, 1'b0, 2'd0); exp_ev(5'b00000, 1'b0, 1); exp_ev(5'b00001, 1'b0, 2);
      repeat (12) tick();

      // overlong packet: head + 6 bodies -> error and release to plane 1
      drive(5'b00011, 1'b1, HEAD); tick();
      for (int i = 0; i < 5; i++) begin
         drive(5'b00011, 1'b1, BODY); tick();
      end
      drive(5'b00011, 1'b1, BODY); exp_ev(5'b00010, 1'b1, 1); tick();

      // asynchronous reset mid-packet
      drive(5'b00011, 1'b1, HEAD); tick();
      drive(5'b00011, 1'b1, BODY); tick();
      drive(5'b00000, 1'b0, 2'd0); rst = 1'b0; exp_ev(5'b00000, 1'b0, 0);
      tick(); tick(); rst = 1'b1; tick();

      // plane 0 first again; body in GRANTED errors; single tail flit re-arbitrates
      drive(5'b00101, 1'b0, 2'd0); exp_ev(5'b00001, 1'b0, 1); tick();
      drive(5'b00101, 1'b1, BODY); exp_ev(5'b00001, 1'b1, 1); tick();
      drive(5'b00101, 1'b1, TAIL); exp_ev(5'b00100, 1'b1, 1); tick();
      drive(5'b00000, 1'b0, 2'd0); exp_ev(5'b00000, 1'b1, 1); tick(); tick();
      rst = 1'b0; exp_ev(5'b00000, 1'b0, 0); tick(); rst = 1'b1; tick();

      // pop while idle
      drive(5'b00000, 1'b1, BODY); exp_ev(5'b00000, 1'b1, 1); tick();
      drive(5'b00000, 1'b0, 2'd0);
      repeat (3) tick();

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_events left=%0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
